// File: rtl/dmem_arbiter_if.sv
// Request, response and memory-side signals of the two-port data memory arbiter.
// Handshake: an access completes in the cycle where reqN_valid and reqN_ready are both high;
// the requester holds valid and payload stable until then, and ready never depends on rsp signals.
interface dmem_arbiter_if;
   logic        req0_valid, req1_valid;
   logic        req0_write, req1_write;
   logic        req0_lock,  req1_lock;
   logic [31:0] req0_addr,  req1_addr;
   logic [31:0] req0_wdata, req1_wdata;
   logic        req0_ready, req1_ready;
   logic        rsp0_valid, rsp1_valid;
   logic [31:0] rsp0_rdata, rsp1_rdata;
   logic        rsp0_err,   rsp1_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_write;
   logic [31:0] mem_rdata;

   modport slave (
      input  req0_valid, req1_valid, req0_write, req1_write, req0_lock, req1_lock,
      input  req0_addr, req1_addr, req0_wdata, req1_wdata, mem_rdata,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
      output rsp0_err, rsp1_err, mem_addr, mem_wdata, mem_write
   );

   modport master (
      output req0_valid, req1_valid, req0_write, req1_write, req0_lock, req1_lock,
      output req0_addr, req1_addr, req0_wdata, req1_wdata, mem_rdata,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
      input  rsp0_err, rsp1_err, mem_addr, mem_wdata, mem_write
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port word-addressed data memory, with round-robin or
// fixed priority selection, lock ownership for read-modify-write, and a lock idle timeout.
module dmem_arbiter #(
   parameter int DATA_MEM_SIZE = 64,
   parameter int PRIO_MODE     = 0,
   parameter int LOCK_MAX      = 16
) (
   input  logic       clk,
   input  logic       rst,
   dmem_arbiter_if.slave bus,
   output logic [1:0] state
);
   typedef enum logic [1:0] {IDLE = 2'd0, LOCK0 = 2'd1, LOCK1 = 2'd2} arb_state_t;

   localparam logic [29:0] IDX_LIMIT = 30'(DATA_MEM_SIZE);
   localparam logic [7:0]  CNT_LAST  = 8'(LOCK_MAX - 1);

   arb_state_t  fsm;
   logic        last_grant;
   logic [7:0]  lock_cnt;
   logic        grant0, grant1;
   logic [31:0] win_addr, win_wdata;
   logic        win_write, win_err;

   // Grants are purely combinational and forced low while reset is held.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rst) begin
         case (fsm)
            LOCK0:   grant0 = bus.req0_valid;
            LOCK1:   grant1 = bus.req1_valid;
            default: begin
               grant0 = bus.req0_valid && (!bus.req1_valid || PRIO_MODE != 0 || last_grant);
               grant1 = bus.req1_valid && !grant0;
            end
         endcase
      end
   end

   assign win_addr  = grant1 ? bus.req1_addr  : bus.req0_addr;
   assign win_wdata = grant1 ? bus.req1_wdata : bus.req0_wdata;
   assign win_write = grant1 ? bus.req1_write : bus.req0_write;
   assign win_err   = win_addr[31:2] >= IDX_LIMIT;

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;
   assign bus.mem_addr   = win_addr;
   assign bus.mem_wdata  = win_wdata;
   assign bus.mem_write  = (grant0 || grant1) && win_write && !win_err;
   assign state          = fsm;

   always_ff @(posedge clk) begin
      if (!rst) begin
         fsm            <= IDLE;
         last_grant     <= 1'b1;
         lock_cnt       <= '0;
         bus.rsp0_valid <= 1'b0;
         bus.rsp1_valid <= 1'b0;
         bus.rsp0_rdata <= '0;
         bus.rsp1_rdata <= '0;
         bus.rsp0_err   <= 1'b0;
         bus.rsp1_err   <= 1'b0;
      end else begin
         bus.rsp0_valid <= grant0;
         bus.rsp1_valid <= grant1;
         bus.rsp0_err   <= grant0 && win_err;
         bus.rsp1_err   <= grant1 && win_err;
         bus.rsp0_rdata <= (grant0 && !bus.req0_write && !win_err) ? bus.mem_rdata : '0;
         bus.rsp1_rdata <= (grant1 && !bus.req1_write && !win_err) ? bus.mem_rdata : '0;
         if (grant0 || grant1) last_grant <= grant1;

         // An owner request always clears the idle counter, so it beats the timeout.
         case (fsm)
            LOCK0: begin
               if (grant0) begin
                  fsm      <= bus.req0_lock ? LOCK0 : IDLE;
                  lock_cnt <= '0;
               end else if (lock_cnt == CNT_LAST) begin
                  fsm      <= IDLE;
                  lock_cnt <= '0;
               end else begin
                  lock_cnt <= lock_cnt + 8'd1;
               end
            end
            LOCK1: begin
               if (grant1) begin
                  fsm      <= bus.req1_lock ? LOCK1 : IDLE;
                  lock_cnt <= '0;
               end else if (lock_cnt == CNT_LAST) begin
                  fsm      <= IDLE;
                  lock_cnt <= '0;
               end else begin
                  lock_cnt <= lock_cnt + 8'd1;
               end
            end
            default: begin
               lock_cnt <= '0;
               if (grant0 && bus.req0_lock)      fsm <= LOCK0;
               else if (grant1 && bus.req1_lock) fsm <= LOCK1;
               else                              fsm <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port, word-addressed data memory between two requesters: port 0 (CPU load/store stage) and port 1 (DMA/debug loader).
- Sits directly in front of the data memory and drives its address, write_data and mem_write inputs. It takes the memory's combinational read_data and returns it to the winning requester.
- Arbitrates per cycle, either round-robin or fixed-priority, and supports a lock for atomic read-modify-write sequences.

Parameters:
- DATA_MEM_SIZE, 64, number of 32-bit words in the data memory. Legal word index is 0..DATA_MEM_SIZE-1.
- PRIO_MODE, 0, 0 = round-robin between ports; 1 = fixed priority, port 0 always wins.
- LOCK_MAX, 16, idle cycles allowed in a locked state before the lock auto-releases (1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- req0_valid / req1_valid  input  1  request from port 0 / port 1.
- req0_write / req1_write  input  1  1 = store, 0 = load.
- req0_lock / req1_lock  input  1  hold ownership after this access.
- req0_addr / req1_addr  input  32  byte address; bits [1:0] are ignored.
- req0_wdata / req1_wdata  input  32  store data.
- req0_ready / req1_ready  output  1  combinational grant; the access completes in this cycle.
- rsp0_valid / rsp1_valid  output  1  registered, one-cycle pulse, the cycle after the grant.
- rsp0_rdata / rsp1_rdata  output  32  load data; 0 for stores and for errors.
- rsp0_err / rsp1_err  output  1  out-of-range address; valid together with rspN_valid.
- mem_addr  output  32  to the memory addr input.
- mem_wdata  output  32  to the memory write_data input.
- mem_write  output  1  to the memory mem_write input.
- mem_rdata  input  32  from the memory read_data output.

Behaviour:
- Reset (rst=0 at posedge clk):
  - state=IDLE, last_grant=1 (so port 0 wins the first tie), lock_cnt=0.
  - All rspN_valid, rspN_rdata and rspN_err registers = 0.
  - While rst=0: all readyN=0 and mem_write=0, combinationally.
  - Reset mid-lock discards the lock. Responses still in flight are dropped, never delivered.
- Handshake:
  - An access completes in the cycle where reqN_valid=1 and reqN_ready=1.
  - A requester keeps valid and its payload stable until it sees ready.
  - ready never depends on rsp signals.
- Grant selection by state:
  - IDLE, PRIO_MODE=0: a single valid port wins. If both ports are valid, the port != last_grant wins.
  - IDLE, PRIO_MODE=1: if both ports are valid, port 0 wins.
  - LOCK0 / LOCK1: only the owning port can be granted. The other port stalls (ready=0) regardless of priority mode.
- last_grant updates to the winner on every completed access.
- Memory drive:
  - mem_addr and mem_wdata mux from the winner. With no winner they show port 0's inputs.
  - mem_write = winner's write AND no range error.
  - Range error when addr[31:2] >= DATA_MEM_SIZE. An erroring store never writes memory. An erroring load returns rdata=0.
- Response, registered at the grant edge:
  - rspN_valid=1 one cycle after the grant, for exactly one cycle.
  - For loads, rspN_rdata = mem_rdata sampled in the grant cycle. Stores give rdata=0.
  - Load-to-use latency is 1 cycle. Back-to-back grants to the same port give back-to-back responses.
- FSM:
  - IDLE -> LOCKn: on granting port n with reqn_lock=1. lock_cnt cleared.
  - LOCKn -> LOCKn: on a port-n grant with lock=1. lock_cnt cleared.
  - LOCKn -> IDLE: on a port-n grant with lock=0. That access still completes.
  - LOCKn, no port-n request: lock_cnt increments. When lock_cnt reaches LOCK_MAX-1 with still no request, go to IDLE and clear lock_cnt.
  - An erroring access follows the same lock transitions.
- Simultaneous events: in a locked state, the owner's request and the timeout cannot both fire. A request clears the counter, so the request takes precedence.

Test Plan:
- Port 0 store addr=0x10, wdata=0xDEADBEEF; next cycle port 1 load addr=0x10 -> ready0 in cycle 0 with mem_write=1; rsp1_valid in cycle 2 with rdata=0xDEADBEEF, err=0.
- PRIO_MODE=0, both ports load continuously for 6 cycles after reset -> grants alternate 0,1,0,1,0,1; each rsp follows its grant by exactly 1 cycle.
- PRIO_MODE=1, both ports valid for 4 cycles -> port 0 granted every cycle, ready1=0 throughout.
- Port 1 load addr=0x8 with lock=1, then store addr=0x8 with lock=0; port 0 valid throughout -> port 0 stalls for both accesses and is granted the cycle after the unlock.
- Lock timeout, LOCK_MAX=4: port 0 lock load then idle; port 1 valid -> ready1 stays 0 for 4 cycles, then port 1 is granted.
- Error and reset: store addr=0x100 (index 64) -> mem_write=0, rsp_err=1 next cycle, memory unchanged. Then assert rst=0 during a lock -> next cycle state=IDLE and no rsp_valid pulse.
